// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: round-robin sharing of one wait-stated memory between fetch and data ports
module mips_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_read,
  input  logic [ADDR_W-1:0] instr_address,
  output logic [31:0]       instr_readdata,
  output logic              instr_ack,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [ADDR_W-1:0] data_address,
  input  logic [31:0]       data_writedata,
  input  logic [3:0]        data_byteenable,
  output logic [31:0]       data_readdata,
  output logic              data_ack,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_byteenable,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  output logic              bus_error
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, INSTR, DATA, RESP} state_t;
  state_t state;
  logic last_data;
  logic [CW-1:0] cnt;
  logic pick_data, expired, finish;
  logic [31:0] rd;
  assign pick_data = (data_read | data_write) & (~instr_read | ~last_data);
  assign expired = mem_waitrequest & (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign finish = ~mem_waitrequest | expired;
  assign rd = expired ? 32'hDEADBEEF : mem_readdata;
  // Grant, hold the latched command until accepted or timed out, then ack for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_data <= 1'b0;
      cnt <= '0;
      instr_ack <= 1'b0;
      data_ack <= 1'b0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_address <= '0;
      mem_writedata <= '0;
      mem_byteenable <= '0;
      instr_readdata <= '0;
      data_readdata <= '0;
      bus_error <= 1'b0;
    end else begin
      instr_ack <= 1'b0;
      data_ack <= 1'b0;
      case (state)
        IDLE:
          if (pick_data) begin
            state <= DATA;
            last_data <= 1'b1;
            cnt <= '0;
            mem_address <= data_address;
            mem_writedata <= data_writedata;
            mem_byteenable <= data_byteenable;
            mem_write <= data_write;
            mem_read <= ~data_write;
          end else if (instr_read) begin
            state <= INSTR;
            last_data <= 1'b0;
            cnt <= '0;
            mem_address <= instr_address;
            mem_byteenable <= 4'hF;
            mem_write <= 1'b0;
            mem_read <= 1'b1;
          end
        INSTR, DATA:
          if (finish) begin
            state <= RESP;
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            instr_ack <= state == INSTR;
            data_ack <= state == DATA;
            bus_error <= bus_error | expired;
            if (mem_read && state == INSTR) instr_readdata <= rd;
            if (mem_read && state == DATA) data_readdata <= rd;
          end else begin
            cnt <= cnt + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
